// File: rtl/divider_pkg.sv
// divider_pkg: shared state encoding, default width and error fill for the divider
package divider_pkg;
  localparam int DEF_WIDTH = 32;
  localparam logic ERR_FILL = 1'b1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step producing a quotient bit
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_r,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_r,
  output logic             o_qbit
);
  logic [WIDTH:0] w_t;
  logic [WIDTH:0] w_diff;
  assign w_t    = {i_r, i_bit};
  assign w_diff = w_t - {1'b0, i_d};
  assign o_qbit = w_t >= {1'b0, i_d};
  assign o_r    = o_qbit ? w_diff[WIDTH-1:0] : w_t[WIDTH-1:0];
endmodule

// File: rtl/divider_64by32.sv
// divider_64by32: iterative restoring 2W/W divider with STB/ACK handshake
module divider_64by32
  import divider_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               I_STB,
  output logic               I_ACK,
  input  logic [2*WIDTH-1:0] I_DAT_A,
  input  logic [WIDTH-1:0]   I_DAT_B,
  output logic               O_STB,
  output logic [2*WIDTH-1:0] O_DAT,
  output logic               O_ERR,
  input  logic               O_ACK
);
  localparam int CW = $clog2(WIDTH + 1);
  state_t             r_state;
  state_t             w_next;
  logic [WIDTH-1:0]   r_r;
  logic [WIDTH-1:0]   r_q;
  logic [WIDTH-1:0]   r_d;
  logic [WIDTH-1:0]   w_r;
  logic               w_qbit;
  logic               w_err;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_dat;
  logic               r_err;
  // A high half not below the divisor means the quotient cannot fit in WIDTH bits
  assign w_err = (I_DAT_B == '0) || (I_DAT_A[2*WIDTH-1:WIDTH] >= I_DAT_B);
  div_step #(.WIDTH(WIDTH)) u_step (
    .i_r   (r_r),
    .i_bit (r_q[WIDTH-1]),
    .i_d   (r_d),
    .o_r   (w_r),
    .o_qbit(w_qbit)
  );
  assign I_ACK = (r_state == IDLE);
  assign O_STB = (r_state == DONE);
  assign O_DAT = r_dat;
  assign O_ERR = r_err;
  // next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = I_STB ? (w_err ? DONE : BUSY) : IDLE;
      BUSY:    w_next = (r_cnt == CW'(1)) ? DONE : BUSY;
      DONE:    w_next = O_ACK ? IDLE : DONE;
      default: w_next = IDLE;
    endcase
  end
  // state register and datapath: load on acceptance, one quotient bit per BUSY edge
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_r     <= '0;
      r_q     <= '0;
      r_d     <= '0;
      r_cnt   <= '0;
      r_dat   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && I_STB) begin
        if (w_err) begin
          r_dat <= {2*WIDTH{ERR_FILL}};
          r_err <= 1'b1;
        end else begin
          r_r   <= I_DAT_A[2*WIDTH-1:WIDTH];
          r_q   <= I_DAT_A[WIDTH-1:0];
          r_d   <= I_DAT_B;
          r_cnt <= CW'(WIDTH);
        end
      end else if (r_state == BUSY) begin
        r_r   <= w_r;
        r_q   <= {r_q[WIDTH-2:0], w_qbit};
        r_cnt <= r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          r_dat <= {w_r, r_q[WIDTH-2:0], w_qbit};
          r_err <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_divider_64by32.sv
// tb_divider_64by32: directed and random scoreboard checks of the 64/32 divider
module tb_divider_64by32;
  logic        CLK;
  logic        RST;
  logic        I_STB;
  logic        I_ACK;
  logic [63:0] I_DAT_A;
  logic [31:0] I_DAT_B;
  logic        O_STB;
  logic [63:0] O_DAT;
  logic        O_ERR;
  logic        O_ACK;
  int          total;
  int          bad;
  logic [64:0] sb[$];
  divider_64by32 dut (
    .CLK    (CLK),
    .RST    (RST),
    .I_STB  (I_STB),
    .I_ACK  (I_ACK),
    .I_DAT_A(I_DAT_A),
    .I_DAT_B(I_DAT_B),
    .O_STB  (O_STB),
    .O_DAT  (O_DAT),
    .O_ERR  (O_ERR),
    .O_ACK  (O_ACK)
  );
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  function automatic logic [64:0] model(input logic [63:0] a, input logic [31:0] b);
    logic [63:0] qq;
    logic [63:0] rr;
    if (b == 32'd0 || a[63:32] >= b) return {1'b1, {64{1'b1}}};
    qq = a / {32'd0, b};
    rr = a % {32'd0, b};
    return {1'b0, rr[31:0], qq[31:0]};
  endfunction
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic start(input logic [63:0] a, input logic [31:0] b, input bit push);
    int n;
    n = 0;
    while (!I_ACK && n < 100) begin
      @(negedge CLK);
      n++;
    end
    chk("iack_wait", I_ACK, 1);
    I_DAT_A = a;
    I_DAT_B = b;
    I_STB   = 1'b1;
    @(posedge CLK);
    if (push) sb.push_back(model(a, b));
    @(negedge CLK);
    I_STB = 1'b0;
  endtask
  task automatic wait_result(input int lat, output logic [64:0] e);
    int n;
    n = 0;
    while (!O_STB && n < 100) begin
      @(negedge CLK);
      n++;
    end
    chk("ostb_timeout", O_STB, 1);
    if (lat >= 0) chk("latency", n, lat);
    chk("sb_nonempty", sb.size() > 0, 1);
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    chk("dat", O_DAT, e[63:0]);
    chk("err", O_ERR, e[64]);
  endtask
  task automatic release_op(input int stall);
    repeat (stall) @(negedge CLK);
    O_ACK = 1'b1;
    @(negedge CLK);
    O_ACK = 1'b0;
    chk("iack_return", I_ACK, 1);
    chk("ostb_clear", O_STB, 0);
  endtask
  initial begin
    logic [64:0] e;
    logic [63:0] a;
    logic [31:0] b;
    logic        seen;
    total = 0;
    bad = 0;
    RST = 1'b1;
    I_STB = 1'b0;
    I_DAT_A = '0;
    I_DAT_B = '0;
    O_ACK = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_iack", I_ACK, 1);
    chk("rst_ostb", O_STB, 0);
    chk("rst_odat", O_DAT, 0);
    chk("rst_oerr", O_ERR, 0);
    RST = 1'b0;
    @(negedge CLK);
    start(64'd100, 32'd7, 1);
    wait_result(32, e);
    chk("basic_const", {O_ERR, O_DAT}, {1'b0, 32'd2, 32'd14});
    release_op(0);
    start(64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF, 1);
    wait_result(32, e);
    chk("maxprod_const", {O_ERR, O_DAT}, {1'b0, 32'd0, 32'hFFFF_FFFF});
    release_op(1);
    start(64'h0000_0000_FFFF_FFFF, 32'd1, 1);
    wait_result(32, e);
    chk("div1_const", {O_ERR, O_DAT}, {1'b0, 32'd0, 32'hFFFF_FFFF});
    release_op(0);
    start(64'd12345, 32'd0, 1);
    wait_result(0, e);
    chk("dz_const", {O_ERR, O_DAT}, {1'b1, 64'hFFFF_FFFF_FFFF_FFFF});
    release_op(2);
    start(64'h0000_0001_0000_0000, 32'd1, 1);
    wait_result(0, e);
    chk("ovf_const", {O_ERR, O_DAT}, {1'b1, 64'hFFFF_FFFF_FFFF_FFFF});
    release_op(0);
    start(64'd5000, 32'd9, 1);
    wait_result(32, e);
    I_DAT_A = 64'd777_777;
    I_DAT_B = 32'd13;
    I_STB = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      chk("hold_dat", {O_ERR, O_DAT}, e);
      chk("hold_iack", I_ACK, 0);
      chk("hold_ostb", O_STB, 1);
    end
    O_ACK = 1'b1;
    @(negedge CLK);
    O_ACK = 1'b0;
    chk("bp_iack", I_ACK, 1);
    @(posedge CLK);
    sb.push_back(model(64'd777_777, 32'd13));
    @(negedge CLK);
    I_STB = 1'b0;
    wait_result(32, e);
    release_op(0);
    start(64'd1000, 32'd3, 0);
    repeat (15) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    chk("mid_rst_iack", I_ACK, 1);
    chk("mid_rst_ostb", O_STB, 0);
    chk("mid_rst_odat", O_DAT, 0);
    chk("mid_rst_oerr", O_ERR, 0);
    RST = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge CLK);
      seen = seen | O_STB;
    end
    chk("mid_rst_no_out", seen, 0);
    start(64'd1000, 32'd3, 1);
    wait_result(32, e);
    chk("q333_const", O_DAT, {32'd1, 32'd333});
    release_op(0);
    for (int i = 0; i < 1000; i++) begin
      b = $urandom;
      if ($urandom_range(0, 15) == 0) b = 32'd0;
      a = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0 && b != 32'd0) a[63:32] = a[63:32] % b;
      start(a, b, 1);
      wait_result(-1, e);
      release_op($urandom_range(0, 3));
    end
    chk("sb_empty_end", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
